// File: rtl/instr_encoder_loader.sv
// Packs opcode/ALU-mode/label/operand fields into 16-bit instruction words and streams them into instruction memory.
// Optional build macro ENC_CHECKSUM_EN enables a running XOR checksum of committed words.
module instr_encoder_loader #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   length,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_opcode,
    input  logic [1:0]    in_alu_sel,
    input  logic [3:0]    in_label,
    input  logic [12:0]   in_fields,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   words_written,
    output logic [15:0]   checksum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   ww_q, ww_d;
    logic          we_q, we_d;
    logic [AW-1:0] maddr_q, maddr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          err_q, err_d;

    logic [15:0]   enc;
    logic          enc_ok;
    logic          ready;
    logic          accept;
    logic          commit;
    logic          session_open;

    always_comb begin
        enc    = '0;
        enc_ok = 1'b0;
        unique case (in_alu_sel)
            2'b00: begin
                enc    = {in_opcode, in_fields[12:0]};
                enc_ok = 1'b1;
            end
            2'b01: begin
                enc    = {in_opcode, in_label, in_fields[8:0]};
                enc_ok = 1'b1;
            end
            2'b10: begin
                // I-form stores only label[3:1]; an odd label cannot round-trip
                enc    = {in_opcode, in_fields[9:0], in_label[3:1]};
                enc_ok = ~in_label[0];
            end
            default: begin
                enc    = '0;
                enc_ok = 1'b0;
            end
        endcase
    end

    assign ready        = (state_q == S_LOAD) && (ww_q != len_q);
    assign accept       = ready && in_valid;
    assign commit       = accept && enc_ok;
    assign session_open = (state_q == S_IDLE) && start;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        ww_d    = ww_q;
        we_d    = 1'b0;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    len_d   = length;
                    ww_d    = '0;
                    err_d   = 1'b0;
                    state_d = (length == '0) ? S_FIN : S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (enc_ok) begin
                        we_d    = 1'b1;
                        maddr_d = addr_q;
                        wdata_d = enc;
                        addr_d  = addr_q + 1'b1;
                        ww_d    = ww_q + 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                // Count reaches length at the final accept; leave after its write cycle
                if (ww_q == len_q) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            ww_q    <= '0;
            we_q    <= 1'b0;
            maddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            ww_q    <= ww_d;
            we_q    <= we_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign in_ready      = ready;
    assign mem_we        = we_q;
    assign mem_addr      = maddr_q;
    assign mem_wdata     = wdata_q;
    assign busy          = (state_q == S_LOAD);
    assign done          = (state_q == S_FIN);
    assign err           = err_q;
    assign words_written = ww_q;

`ifdef ENC_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (session_open) begin
            csum_d = '0;
        end else if (commit) begin
            csum_d = csum_q ^ enc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`else
    logic unused_ok;
    assign unused_ok = session_open ^ commit;
    assign checksum  = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: encoding modes, reject path, address wrap, misuse and reset abort.
module tb_instr_encoder_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_opcode;
    logic [1:0]    in_alu_sel;
    logic [3:0]    in_label;
    logic [12:0]   in_fields;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   words_written;
    logic [15:0]   checksum;

    int unsigned tests = 0;
    int unsigned fails = 0;

    instr_encoder_loader #(.AW(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .length        (length),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_opcode     (in_opcode),
        .in_alu_sel    (in_alu_sel),
        .in_label      (in_label),
        .in_fields     (in_fields),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .words_written (words_written),
        .checksum      (checksum)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic word(input logic [2:0] op, input logic [1:0] sel,
                        input logic [3:0] lab, input logic [12:0] fld);
        in_opcode  = op;
        in_alu_sel = sel;
        in_label   = lab;
        in_fields  = fld;
        in_valid   = 1'b1;
    endtask

    task automatic open_session(input logic [AW-1:0] b, input logic [AW:0] n);
        base_addr = b;
        length    = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; in_valid = 1'b0;
        in_opcode = '0; in_alu_sel = '0; in_label = '0; in_fields = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_ww", words_written, 0);
        chk("rst_csum", checksum, 0);

        // Mode 01, single word
        open_session(8'h10, 1);
        chk("m01_busy", busy, 1);
        chk("m01_ready", in_ready, 1);
        word(3'b001, 2'b01, 4'hA, 13'h0055);
        tick();
        in_valid = 1'b0;
        chk("m01_we", mem_we, 1);
        chk("m01_addr", mem_addr, 32'h10);
        chk("m01_wdata", mem_wdata, 32'h3455);
        chk("m01_ww", words_written, 1);
        chk("m01_ready_drop", in_ready, 0);
        tick();
        chk("m01_done", done, 1);
        chk("m01_busy_fin", busy, 0);
        chk("m01_we_off", mem_we, 0);
        tick();
        chk("m01_done_once", done, 0);

        // Mode 10 then mode 00, back to back
        open_session(8'h20, 2);
        word(3'b010, 2'b10, 4'h6, 13'h03FF);
        tick();
        chk("m10_we", mem_we, 1);
        chk("m10_addr", mem_addr, 32'h20);
        chk("m10_wdata", mem_wdata, 32'h5FFB);
        word(3'b111, 2'b00, 4'hF, 13'h1ABC);
        tick();
        in_valid = 1'b0;
        chk("m00_we", mem_we, 1);
        chk("m00_addr", mem_addr, 32'h21);
        chk("m00_wdata", mem_wdata, 32'hFABC);
        chk("m00_ww", words_written, 2);
        chk("m00_ready", in_ready, 0);
        tick();
        chk("m00_done", done, 1);
        chk("m00_hold_addr", mem_addr, 32'h21);
        chk("m00_hold_wdata", mem_wdata, 32'hFABC);
`ifdef ENC_CHECKSUM_EN
        chk("m00_csum", checksum, 32'hA547);
`else
        chk("m00_csum", checksum, 32'h0);
`endif
        tick();

        // Illegal words are consumed without writing
        open_session(8'h30, 1);
        word(3'b011, 2'b10, 4'h5, 13'h0001);
        tick();
        chk("ill10_we", mem_we, 0);
        chk("ill10_err", err, 1);
        chk("ill10_ww", words_written, 0);
        chk("ill10_ready", in_ready, 1);
        word(3'b011, 2'b11, 4'h2, 13'h0002);
        tick();
        chk("ill11_we", mem_we, 0);
        chk("ill11_err", err, 1);
        word(3'b001, 2'b01, 4'hA, 13'h0055);
        tick();
        in_valid = 1'b0;
        chk("ill_next_we", mem_we, 1);
        chk("ill_next_addr", mem_addr, 32'h30);
        chk("ill_next_wdata", mem_wdata, 32'h3455);
        tick();
        chk("ill_done", done, 1);
        chk("ill_err_sticky", err, 1);
        tick();

        // Address wrap FE..01
        open_session(8'hFE, 4);
        chk("wrap_err_clear", err, 0);
        chk("wrap_csum_clear", checksum, 0);
        word(3'b000, 2'b00, 4'h0, 13'h0001);
        tick();
        chk("wrap0_addr", mem_addr, 32'hFE);
        chk("wrap0_wdata", mem_wdata, 32'h0001);
        chk("wrap0_ready", in_ready, 1);
        in_fields = 13'h0002;
        tick();
        chk("wrap1_addr", mem_addr, 32'hFF);
        chk("wrap1_we", mem_we, 1);
        in_fields = 13'h0003;
        tick();
        chk("wrap2_addr", mem_addr, 32'h00);
        chk("wrap2_we", mem_we, 1);
        in_fields = 13'h0004;
        tick();
        in_valid = 1'b0;
        chk("wrap3_addr", mem_addr, 32'h01);
        chk("wrap3_we", mem_we, 1);
        chk("wrap3_ready", in_ready, 0);
        chk("wrap3_ww", words_written, 4);
        tick();
        chk("wrap_done", done, 1);
        chk("wrap_we_off", mem_we, 0);
        tick();

        // Zero-length session
        open_session(8'h44, 0);
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        chk("len0_we", mem_we, 0);
        tick();
        chk("len0_done_once", done, 0);
        chk("len0_we2", mem_we, 0);

        // start during LOAD is ignored
        open_session(8'h50, 1);
        base_addr = 8'h60;
        length    = 3;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        chk("restart_busy", busy, 1);
        chk("restart_ready", in_ready, 1);
        word(3'b000, 2'b00, 4'h0, 13'h0123);
        tick();
        in_valid = 1'b0;
        chk("restart_addr", mem_addr, 32'h50);
        chk("restart_ready_drop", in_ready, 0);
        tick();
        chk("restart_done", done, 1);
        tick();

        // Checksum over 1234 and 00FF
        open_session(8'h40, 2);
        word(3'b000, 2'b00, 4'h0, 13'h1234);
        tick();
        in_fields = 13'h00FF;
        tick();
        in_valid = 1'b0;
        chk("cs_wdata", mem_wdata, 32'h00FF);
        tick();
        chk("cs_done", done, 1);
`ifdef ENC_CHECKSUM_EN
        chk("cs_value", checksum, 32'h12CB);
`else
        chk("cs_value", checksum, 32'h0);
`endif
        tick();

        // Reset mid-session after 2 of 5 words
        open_session(8'h70, 5);
        word(3'b000, 2'b00, 4'h0, 13'h0011);
        tick();
        in_fields = 13'h0022;
        tick();
        chk("abort_ww", words_written, 2);
        chk("abort_addr_pre", mem_addr, 32'h71);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_we", mem_we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", in_ready, 0);
        chk("abort_addr", mem_addr, 0);
        chk("abort_wdata", mem_wdata, 0);
        chk("abort_ww0", words_written, 0);
        chk("abort_csum", checksum, 0);
        tick();
        chk("abort_we_later", mem_we, 0);
        chk("abort_done", done, 0);
        tick();
        in_valid = 1'b0;
        chk("abort_we_later2", mem_we, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
